// File: rtl/branch_predict_ctrl_if.sv
// Fetch/execute handshake bundle for the branch predictor controller.
// The master side drives lookups and resolves; the slave side (the controller) answers.
interface branch_predict_ctrl_if #(
  parameter int unsigned PC_W   = 16,
  parameter int unsigned QDEPTH = 4
);
  localparam int unsigned CntW = $clog2(QDEPTH) + 1;

  logic            lookup_valid;
  logic [PC_W-1:0] lookup_pc;
  logic            lookup_take;
  logic            lookup_stall;
  logic            resolve_valid;
  logic            resolve_taken;
  logic            mispredict;
  logic            resolve_error;
  logic [CntW-1:0] pending_count;

  modport master (
    output lookup_valid, lookup_pc, resolve_valid, resolve_taken,
    input  lookup_take, lookup_stall, mispredict, resolve_error, pending_count
  );

  modport slave (
    input  lookup_valid, lookup_pc, resolve_valid, resolve_taken,
    output lookup_take, lookup_stall, mispredict, resolve_error, pending_count
  );
endinterface

// File: rtl/branch_predict_ctrl.sv
// 2-bit branch predictor table plus an in-order queue of in-flight predictions.
// Execute resolves the oldest entry; a wrong guess flushes everything younger.
module branch_predict_ctrl #(
  parameter int unsigned PC_W   = 16,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned QDEPTH = 4
) (
  input logic                   iClk,
  input logic                   iRst_n,
  branch_predict_ctrl_if.slave  bp_io
);
  localparam int unsigned PtrW    = $clog2(QDEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned TblSize = 1 << IDX_W;

  typedef logic [1:0] ctr_t;

  ctr_t             table_q [TblSize];
  logic [IDX_W-1:0] q_idx_q [QDEPTH];
  logic             q_pred_q [QDEPTH];

  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             mispredict_q, mispredict_d;
  logic             error_q, error_d;

  logic [IDX_W-1:0] lookup_idx, head_idx;
  logic             head_pred, stall, push, pop, flush;

  // Encoding: 00 NT1, 01 NT2, 10 T1, 11 T2; transitions are deliberately asymmetric.
  function automatic ctr_t ctr_update(ctr_t c, logic taken);
    ctr_t n;
    unique case (c)
      2'b10:   n = taken ? 2'b10 : 2'b11;
      2'b11:   n = taken ? 2'b10 : 2'b00;
      2'b00:   n = taken ? 2'b11 : 2'b01;
      default: n = taken ? 2'b00 : 2'b01;
    endcase
    return n;
  endfunction

  assign lookup_idx = bp_io.lookup_pc[IDX_W+1:2];
  assign head_idx   = q_idx_q[head_q];
  assign head_pred  = q_pred_q[head_q];

  always_comb begin
    stall        = (count_q == CntW'(QDEPTH));
    push         = bp_io.lookup_valid && !stall;
    pop          = bp_io.resolve_valid && (count_q != '0);
    flush        = pop && (bp_io.resolve_taken != head_pred);
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    mispredict_d = flush;
    error_d      = bp_io.resolve_valid && (count_q == '0);
    if (flush) begin
      // Any lookup accepted in the flush cycle is younger than the head, so it dies too.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PtrW'(1);
      if (pop)  head_d = head_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      for (int i = 0; i < TblSize; i++) table_q[i] <= 2'b10;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      mispredict_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      if (pop) table_q[head_idx] <= ctr_update(table_q[head_idx], bp_io.resolve_taken);
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      mispredict_q <= mispredict_d;
      error_q      <= error_d;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst_n && push && !flush) begin
      q_idx_q[tail_q]  <= lookup_idx;
      q_pred_q[tail_q] <= table_q[lookup_idx][1];
    end
  end

  assign bp_io.lookup_take   = table_q[lookup_idx][1];
  assign bp_io.lookup_stall  = stall;
  assign bp_io.mispredict    = mispredict_q;
  assign bp_io.resolve_error = error_q;
  assign bp_io.pending_count = count_q;
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: one task per scenario, inline checks.
module tb_branch_predict_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  branch_predict_ctrl_if #(.PC_W(16), .QDEPTH(4)) bp_if ();

  branch_predict_ctrl #(.PC_W(16), .IDX_W(4), .QDEPTH(4)) dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .bp_io  (bp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bp_if.lookup_valid  = 1'b0;
    bp_if.resolve_valid = 1'b0;
    bp_if.resolve_taken = 1'b0;
  endtask

  task automatic test_reset();
    bp_if.lookup_pc = 16'h0010;
    #1;
    checks++; if (bp_if.pending_count !== 3'd0) begin errors++;
      $display("FAIL rst_count got %0d want 0", bp_if.pending_count); end
    checks++; if (bp_if.lookup_stall !== 1'b0) begin errors++;
      $display("FAIL rst_stall got %b want 0", bp_if.lookup_stall); end
    checks++; if (bp_if.mispredict !== 1'b0 || bp_if.resolve_error !== 1'b0) begin errors++;
      $display("FAIL rst_flags got %b%b want 00", bp_if.mispredict, bp_if.resolve_error); end
    checks++; if (bp_if.lookup_take !== 1'b1) begin errors++;
      $display("FAIL rst_take got %b want 1", bp_if.lookup_take); end
  endtask

  task automatic test_correct_resolve();
    bp_if.lookup_valid = 1'b1; bp_if.lookup_pc = 16'h0010;
    #1;
    checks++; if (bp_if.lookup_take !== 1'b1) begin errors++;
      $display("FAIL cr_take got %b want 1", bp_if.lookup_take); end
    tick(); idle();
    checks++; if (bp_if.pending_count !== 3'd1) begin errors++;
      $display("FAIL cr_count got %0d want 1", bp_if.pending_count); end
    bp_if.resolve_valid = 1'b1; bp_if.resolve_taken = 1'b1;
    tick(); idle();
    checks++; if (bp_if.mispredict !== 1'b0 || bp_if.pending_count !== 3'd0) begin errors++;
      $display("FAIL cr_resolve got mp=%b cnt=%0d want mp=0 cnt=0",
               bp_if.mispredict, bp_if.pending_count); end
    checks++; if (bp_if.lookup_take !== 1'b1) begin errors++;
      $display("FAIL cr_table got %b want 1", bp_if.lookup_take); end
  endtask

  // 10 -not taken-> 11 -not taken-> 00; both predicted taken, so both are wrong.
  task automatic test_mispredict_seq();
    bp_if.lookup_valid = 1'b1; bp_if.lookup_pc = 16'h0010;
    tick(); idle();
    bp_if.resolve_valid = 1'b1; bp_if.resolve_taken = 1'b0;
    tick(); idle();
    checks++; if (bp_if.mispredict !== 1'b1) begin errors++;
      $display("FAIL ms_first got %b want 1", bp_if.mispredict); end
    checks++; if (bp_if.lookup_take !== 1'b1) begin errors++;
      $display("FAIL ms_ctr11 got %b want 1", bp_if.lookup_take); end
    bp_if.lookup_valid = 1'b1;
    tick(); idle();
    checks++; if (bp_if.mispredict !== 1'b0) begin errors++;
      $display("FAIL ms_pulse got %b want 0", bp_if.mispredict); end
    bp_if.resolve_valid = 1'b1; bp_if.resolve_taken = 1'b0;
    tick(); idle();
    checks++; if (bp_if.mispredict !== 1'b1) begin errors++;
      $display("FAIL ms_second got %b want 1", bp_if.mispredict); end
    checks++; if (bp_if.lookup_take !== 1'b0) begin errors++;
      $display("FAIL ms_ctr00 got %b want 0", bp_if.lookup_take); end
  endtask

  task automatic test_full();
    logic [15:0] pcs [4];
    pcs = '{16'h0020, 16'h0024, 16'h0028, 16'h002C};
    for (int i = 0; i < 4; i++) begin
      bp_if.lookup_valid = 1'b1; bp_if.lookup_pc = pcs[i];
      tick();
    end
    idle();
    checks++; if (bp_if.pending_count !== 3'd4 || bp_if.lookup_stall !== 1'b1) begin errors++;
      $display("FAIL full_state got cnt=%0d stall=%b want cnt=4 stall=1",
               bp_if.pending_count, bp_if.lookup_stall); end
    bp_if.lookup_valid = 1'b1; bp_if.lookup_pc = 16'h0030;
    tick(); idle();
    checks++; if (bp_if.pending_count !== 3'd4) begin errors++;
      $display("FAIL full_ignore got %0d want 4", bp_if.pending_count); end
    bp_if.resolve_valid = 1'b1; bp_if.resolve_taken = 1'b1;
    tick(); idle();
    checks++; if (bp_if.pending_count !== 3'd3 || bp_if.lookup_stall !== 1'b0) begin errors++;
      $display("FAIL full_pop got cnt=%0d stall=%b want cnt=3 stall=0",
               bp_if.pending_count, bp_if.lookup_stall); end
    checks++; if (bp_if.mispredict !== 1'b0) begin errors++;
      $display("FAIL full_mp got %b want 0", bp_if.mispredict); end
  endtask

  task automatic test_flush();
    bp_if.lookup_valid  = 1'b1; bp_if.lookup_pc = 16'h0034;
    bp_if.resolve_valid = 1'b1; bp_if.resolve_taken = 1'b0;
    tick(); idle();
    checks++; if (bp_if.mispredict !== 1'b1 || bp_if.pending_count !== 3'd0) begin errors++;
      $display("FAIL flush got mp=%b cnt=%0d want mp=1 cnt=0",
               bp_if.mispredict, bp_if.pending_count); end
    tick();
    checks++; if (bp_if.mispredict !== 1'b0 || bp_if.pending_count !== 3'd0) begin errors++;
      $display("FAIL flush_after got mp=%b cnt=%0d want mp=0 cnt=0",
               bp_if.mispredict, bp_if.pending_count); end
  endtask

  task automatic test_empty_resolve();
    bp_if.lookup_pc = 16'h0010;
    bp_if.resolve_valid = 1'b1; bp_if.resolve_taken = 1'b1;
    tick(); idle();
    checks++; if (bp_if.resolve_error !== 1'b1 || bp_if.pending_count !== 3'd0) begin errors++;
      $display("FAIL empty_err got err=%b cnt=%0d want err=1 cnt=0",
               bp_if.resolve_error, bp_if.pending_count); end
    checks++; if (bp_if.mispredict !== 1'b0) begin errors++;
      $display("FAIL empty_mp got %b want 0", bp_if.mispredict); end
    tick();
    checks++; if (bp_if.resolve_error !== 1'b0) begin errors++;
      $display("FAIL empty_pulse got %b want 0", bp_if.resolve_error); end
    checks++; if (bp_if.lookup_take !== 1'b0) begin errors++;
      $display("FAIL empty_table got %b want 0", bp_if.lookup_take); end
  endtask

  task automatic test_same_cycle();
    bp_if.lookup_valid = 1'b1; bp_if.lookup_pc = 16'h0010;
    tick();
    bp_if.resolve_valid = 1'b1; bp_if.resolve_taken = 1'b1;
    #1;
    checks++; if (bp_if.lookup_take !== 1'b0) begin errors++;
      $display("FAIL sc_pre got %b want 0", bp_if.lookup_take); end
    tick(); idle();
    checks++; if (bp_if.lookup_take !== 1'b1) begin errors++;
      $display("FAIL sc_post got %b want 1", bp_if.lookup_take); end
    checks++; if (bp_if.mispredict !== 1'b1 || bp_if.pending_count !== 3'd0) begin errors++;
      $display("FAIL sc_flush got mp=%b cnt=%0d want mp=1 cnt=0",
               bp_if.mispredict, bp_if.pending_count); end
  endtask

  task automatic test_back_to_back();
    bp_if.lookup_valid = 1'b1; bp_if.lookup_pc = 16'h0010;
    tick();
    bp_if.resolve_valid = 1'b1; bp_if.resolve_taken = 1'b1;
    tick(); idle();
    checks++; if (bp_if.pending_count !== 3'd1 || bp_if.mispredict !== 1'b0) begin errors++;
      $display("FAIL b2b_pushpop got cnt=%0d mp=%b want cnt=1 mp=0",
               bp_if.pending_count, bp_if.mispredict); end
    bp_if.resolve_valid = 1'b1; bp_if.resolve_taken = 1'b1;
    tick(); idle();
    checks++; if (bp_if.pending_count !== 3'd0 || bp_if.mispredict !== 1'b0) begin errors++;
      $display("FAIL b2b_drain got cnt=%0d mp=%b want cnt=0 mp=0",
               bp_if.pending_count, bp_if.mispredict); end
    checks++; if (bp_if.lookup_take !== 1'b1) begin errors++;
      $display("FAIL b2b_table got %b want 1", bp_if.lookup_take); end
  endtask

  // Drive idx 12 down to 00, then reset on the edge of a would-be mispredict.
  task automatic test_reset_midop();
    bp_if.lookup_pc = 16'h0030;
    for (int i = 0; i < 2; i++) begin
      bp_if.lookup_valid = 1'b1;
      tick(); idle();
      bp_if.resolve_valid = 1'b1; bp_if.resolve_taken = 1'b0;
      tick(); idle();
    end
    checks++; if (bp_if.lookup_take !== 1'b0) begin errors++;
      $display("FAIL rm_pre got %b want 0", bp_if.lookup_take); end
    bp_if.lookup_valid = 1'b1;
    tick(); idle();
    bp_if.resolve_valid = 1'b1; bp_if.resolve_taken = 1'b1; rst_n = 1'b0;
    tick(); idle(); rst_n = 1'b1;
    checks++; if (bp_if.mispredict !== 1'b0 || bp_if.resolve_error !== 1'b0) begin errors++;
      $display("FAIL rm_flags got %b%b want 00", bp_if.mispredict, bp_if.resolve_error); end
    checks++; if (bp_if.pending_count !== 3'd0) begin errors++;
      $display("FAIL rm_count got %0d want 0", bp_if.pending_count); end
    checks++; if (bp_if.lookup_take !== 1'b1) begin errors++;
      $display("FAIL rm_table got %b want 1", bp_if.lookup_take); end
    tick();
    checks++; if (bp_if.mispredict !== 1'b0) begin errors++;
      $display("FAIL rm_after got %b want 0", bp_if.mispredict); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bp_if.lookup_pc = 16'h0000;
    idle();
    tick(); tick();
    rst_n = 1'b1;
    test_reset();
    test_correct_resolve();
    test_mispredict_seq();
    test_full();
    test_flush();
    test_empty_resolve();
    test_same_cycle();
    test_back_to_back();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
